// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes switches and debounces/edge-detects pushbuttons from raw board pins.
module input_conditioner #(
  parameter int SW_WIDTH        = 18,
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic [SW_WIDTH-1:0] SW,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [SW_WIDTH-1:0] sw_sync,
  output logic                sw_change,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam bit SHORT = (DEBOUNCE_CYCLES == 1);
  localparam logic [1:0] UP = 2'd0, CNT_DN = 2'd1, DOWN = 2'd2, CNT_UP = 2'd3;
  logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q, sw_prev_q;
  logic [NUM_KEYS-1:0] key_s1_q, key_s2_q, pressed;
  logic [1:0] warm_q, warm_d;
  logic sw_change_q, sw_change_d;
  logic [1:0] state_q [NUM_KEYS];
  logic [1:0] state_d [NUM_KEYS];
  logic [CW-1:0] cnt_q [NUM_KEYS];
  logic [CW-1:0] cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_q, level_d, press_q, press_d, release_q, release_d;
  assign pressed = ~key_s2_q;
  assign sw_sync = sw_s2_q;
  assign sw_change = sw_change_q;
  assign key_level = level_q;
  assign key_press = press_q;
  assign key_release = release_q;
  // Warm-up masks the compare until the sync pipeline and prev register hold real pin data.
  always_comb begin
    warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    sw_change_d = (warm_q == 2'd3) && (sw_s2_q != sw_prev_q);
  end
  always_comb begin
    level_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i] = cnt_q[i];
      case (state_q[i])
        UP: if (pressed[i]) begin
          state_d[i] = SHORT ? DOWN : CNT_DN;
          cnt_d[i] = SHORT ? '0 : CNT_ONE;
        end
        CNT_DN: if (!pressed[i]) begin
          state_d[i] = UP;
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          state_d[i] = DOWN;
          cnt_d[i] = '0;
        end else cnt_d[i] = cnt_q[i] + CNT_ONE;
        DOWN: if (!pressed[i]) begin
          state_d[i] = SHORT ? UP : CNT_UP;
          cnt_d[i] = SHORT ? '0 : CNT_ONE;
        end
        default: if (pressed[i]) begin
          state_d[i] = DOWN;
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          state_d[i] = UP;
          cnt_d[i] = '0;
        end else cnt_d[i] = cnt_q[i] + CNT_ONE;
      endcase
      level_d[i] = (state_q[i] == DOWN) || (state_q[i] == CNT_UP);
    end
    press_d = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      sw_prev_q <= '0;
      key_s1_q <= '1;
      key_s2_q <= '1;
      warm_q <= '0;
      sw_change_q <= 1'b0;
      level_q <= '0;
      press_q <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= UP;
        cnt_q[i] <= '0;
      end
    end else begin
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
      sw_prev_q <= sw_s2_q;
      key_s1_q <= KEY;
      key_s2_q <= key_s1_q;
      warm_q <= warm_d;
      sw_change_q <= sw_change_d;
      level_q <= level_d;
      press_q <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
endmodule
